// File: rtl/layer_compositor_if.sv
// Pixel bus of layer_compositor: hit-time video/layer inputs, per-frame requests and
// the composited, registered outputs.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter int LSEL_W     = $clog2(NUM_LAYERS + 1)
);
  logic                          in_valid;
  logic                          in_hsync;
  logic                          in_vsync;
  logic                          frame_start;
  logic [NUM_LAYERS-1:0]         layer_hit;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         layer_en_req;
  logic [NUM_LAYERS-1:0]         blend_req;
  logic [COLOR_W-1:0]            out_rgb;
  logic                          out_hsync;
  logic                          out_vsync;
  logic                          out_valid;
  logic [LSEL_W-1:0]             out_layer;
  logic                          collide;
  logic [15:0]                   overlap_cnt;

  modport master (
    output in_valid, in_hsync, in_vsync, frame_start, layer_hit, layer_rgb,
           layer_en_req, blend_req,
    input  out_rgb, out_hsync, out_vsync, out_valid, out_layer, collide, overlap_cnt
  );

  modport slave (
    input  in_valid, in_hsync, in_vsync, frame_start, layer_hit, layer_rgb,
           layer_en_req, blend_req,
    output out_rgb, out_hsync, out_vsync, out_valid, out_layer, collide, overlap_cnt
  );
endinterface

// File: rtl/layer_compositor.sv
// Pipelined layer compositor: aligns hit flags with BRAM colour, picks the highest-priority
// opaque layer (optional 50 % blend), shadows per-frame settings and counts per-frame collisions.
module layer_compositor #(
  parameter int                 NUM_LAYERS  = 4,
  parameter int                 COLOR_W     = 12,
  parameter int                 MEM_LAT     = 1,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 12'h000,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 12'h6B4,
  parameter int                 COLL_A      = 0,
  parameter int                 COLL_B      = 1,
  parameter int                 LSEL_W      = $clog2(NUM_LAYERS + 1)
) (
  input logic               clk,
  input logic               rst,
  layer_compositor_if.slave bus
);
  localparam int                CH_W     = COLOR_W / 3;
  localparam int                ST_W     = NUM_LAYERS + 4;
  localparam logic [ST_W-1:0]   ST_RST   = {1'b0, 1'b1, 1'b1, 1'b0, {NUM_LAYERS{1'b0}}};
  localparam logic [LSEL_W-1:0] NO_LAYER = LSEL_W'(NUM_LAYERS);

  function automatic logic [COLOR_W-1:0] half_mix(input logic [COLOR_W-1:0] w,
                                                  input logic [COLOR_W-1:0] u);
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*CH_W +: CH_W] = (w[c*CH_W +: CH_W] >> 1'b1) + (u[c*CH_W +: CH_W] >> 1'b1);
    end
    return r;
  endfunction

  logic [ST_W-1:0] st_in;
  logic [ST_W-1:0] st_a;
  assign st_in = {bus.in_valid, bus.in_hsync, bus.in_vsync, bus.frame_start, bus.layer_hit};

  generate
    if (MEM_LAT == 0) begin : g_no_align
      assign st_a = st_in;
    end else begin : g_align
      logic [ST_W-1:0] pipe_q [MEM_LAT];
      logic [ST_W-1:0] pipe_d [MEM_LAT];

      // Shift hit-time controls so they meet the BRAM data MEM_LAT cycles later.
      always_comb begin
        pipe_d[0] = st_in;
        for (int i = 1; i < MEM_LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Alignment registers; sync stages idle high.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MEM_LAT; i++) begin
            pipe_q[i] <= ST_RST;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign st_a = pipe_q[MEM_LAT-1];
    end
  endgenerate

  logic                  a_valid, a_hsync, a_vsync, a_fs;
  logic [NUM_LAYERS-1:0] a_hit;
  assign {a_valid, a_hsync, a_vsync, a_fs, a_hit} = st_a;

  logic [NUM_LAYERS-1:0] act_en_q, act_en_d, act_blend_q, act_blend_d;
  logic [NUM_LAYERS-1:0] en_eff, blend_eff, opaque, visible;
  logic                  acc_flag_q, acc_flag_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;
  logic [COLOR_W-1:0]    out_rgb_q, out_rgb_d;
  logic                  out_hsync_q, out_hsync_d, out_vsync_q, out_vsync_d;
  logic                  out_valid_q, out_valid_d;
  logic [LSEL_W-1:0]     out_layer_q, out_layer_d;
  logic                  collide_q, collide_d;
  logic [15:0]           overlap_cnt_q, overlap_cnt_d;
  logic                  win_found, win_blend, und_found, take_win, take_und, overlap;
  logic [LSEL_W-1:0]     win_idx;
  logic [COLOR_W-1:0]    win_rgb, und_rgb, lay_rgb;

  // Opacity per layer, then the lowest visible index and the next visible one beneath it.
  always_comb begin
    en_eff    = a_fs ? bus.layer_en_req : act_en_q;
    blend_eff = a_fs ? bus.blend_req    : act_blend_q;
    opaque    = '0;
    visible   = '0;
    lay_rgb   = '0;
    take_win  = 1'b0;
    take_und  = 1'b0;
    win_found = 1'b0;
    win_blend = 1'b0;
    und_found = 1'b0;
    win_idx   = NO_LAYER;
    win_rgb   = BG_COLOR;
    und_rgb   = BG_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lay_rgb    = bus.layer_rgb[i*COLOR_W +: COLOR_W];
      opaque[i]  = a_hit[i] && (lay_rgb != TRANSPARENT);
      visible[i] = opaque[i] && en_eff[i];
      take_win   = visible[i] && !win_found;
      take_und   = visible[i] && win_found && !und_found;
      win_idx    = take_win ? LSEL_W'(i)   : win_idx;
      win_rgb    = take_win ? lay_rgb      : win_rgb;
      win_blend  = take_win ? blend_eff[i] : win_blend;
      und_rgb    = take_und ? lay_rgb      : und_rgb;
      win_found  = win_found || take_win;
      und_found  = und_found || take_und;
    end
  end

  // Shadow registers, per-frame collision accumulator and output next-state.
  always_comb begin
    overlap     = a_valid && opaque[COLL_A] && opaque[COLL_B];
    act_en_d    = en_eff;
    act_blend_d = blend_eff;
    if (a_fs) begin
      collide_d     = acc_flag_q;
      overlap_cnt_d = acc_cnt_q;
      acc_flag_d    = overlap;
      acc_cnt_d     = {15'd0, overlap};
    end else begin
      collide_d     = collide_q;
      overlap_cnt_d = overlap_cnt_q;
      acc_flag_d    = acc_flag_q || overlap;
      acc_cnt_d     = (overlap && (acc_cnt_q != 16'hFFFF)) ? acc_cnt_q + 16'd1 : acc_cnt_q;
    end
    if (!a_valid) begin
      out_rgb_d   = '0;
      out_layer_d = NO_LAYER;
    end else if (!win_found) begin
      out_rgb_d   = BG_COLOR;
      out_layer_d = NO_LAYER;
    end else if (win_blend) begin
      out_rgb_d   = half_mix(win_rgb, und_rgb);
      out_layer_d = win_idx;
    end else begin
      out_rgb_d   = win_rgb;
      out_layer_d = win_idx;
    end
    out_hsync_d = a_hsync;
    out_vsync_d = a_vsync;
    out_valid_d = a_valid;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_en_q      <= '1;
      act_blend_q   <= '0;
      acc_flag_q    <= 1'b0;
      acc_cnt_q     <= 16'h0000;
      out_rgb_q     <= '0;
      out_hsync_q   <= 1'b1;
      out_vsync_q   <= 1'b1;
      out_valid_q   <= 1'b0;
      out_layer_q   <= NO_LAYER;
      collide_q     <= 1'b0;
      overlap_cnt_q <= 16'h0000;
    end else begin
      act_en_q      <= act_en_d;
      act_blend_q   <= act_blend_d;
      acc_flag_q    <= acc_flag_d;
      acc_cnt_q     <= acc_cnt_d;
      out_rgb_q     <= out_rgb_d;
      out_hsync_q   <= out_hsync_d;
      out_vsync_q   <= out_vsync_d;
      out_valid_q   <= out_valid_d;
      out_layer_q   <= out_layer_d;
      collide_q     <= collide_d;
      overlap_cnt_q <= overlap_cnt_d;
    end
  end

  assign bus.out_rgb     = out_rgb_q;
  assign bus.out_hsync   = out_hsync_q;
  assign bus.out_vsync   = out_vsync_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_layer   = out_layer_q;
  assign bus.collide     = collide_q;
  assign bus.overlap_cnt = overlap_cnt_q;

  layer_compositor_checker #(.COLL_A(COLL_A), .COLL_B(COLL_B)) u_chk (
    .clk (clk),
    .rst (rst)
  );
endmodule

// Collision layers must differ; two copies of one layer would always "collide".
module layer_compositor_checker #(
  parameter int COLL_A = 0,
  parameter int COLL_B = 1
) (
  input logic clk,
  input logic rst
);
  a_coll_distinct: assert property (@(posedge clk) disable iff (rst) COLL_A != COLL_B);
endmodule
